// File: rtl/set_cache_srrip_policy_controller.sv
// SRRIP replacement controller: per-group RRPV array, multi-cycle victim search/aging FSM.
// Optional bimodal (BRRIP) insertion is enabled with `define SRRIP_BIMODAL_INSERT_EN.
module set_cache_srrip_policy_controller #(
  parameter int CACHE_BLOCK_CAPACITY = 128,
  parameter int CACHE_SET_SIZE       = 4,
  parameter int BW_RRPV              = 2
) (
  input  logic                                    clock_i,
  input  logic                                    resetn_i,
  input  logic                                    hit_i,
  input  logic                                    miss_i,
  input  logic [$clog2(CACHE_BLOCK_CAPACITY)-1:0] addr_i,
  output logic                                    done_o,
  output logic                                    busy_o,
  output logic [$clog2(CACHE_BLOCK_CAPACITY)-1:0] addr_o
);

  localparam int BW_CACHE_CAPACITY = $clog2(CACHE_BLOCK_CAPACITY);
  localparam int BW_SET            = $clog2(CACHE_SET_SIZE);
  localparam int BW_GRP            = BW_CACHE_CAPACITY - BW_SET;
  localparam int N_GROUPS          = 2 ** BW_GRP;

  localparam logic [BW_RRPV-1:0] RRPV_MAX  = '1;
  // Clearing the LSB of an all-ones value yields RRPV_MAX-1 for every width.
  localparam logic [BW_RRPV-1:0] RRPV_LONG = RRPV_MAX ^ BW_RRPV'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_AGE,
    S_DONE,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [BW_GRP-1:0]   grp_q;
  logic [BW_RRPV-1:0]  rrpv_q [N_GROUPS][CACHE_SET_SIZE];

  logic                found;
  logic [BW_SET-1:0]   found_way;
  logic [BW_RRPV-1:0]  ins_val;

  wire [BW_GRP-1:0] hit_grp    = addr_i[BW_GRP-1:0];
  wire [BW_SET-1:0] hit_way    = addr_i[BW_CACHE_CAPACITY-1 -: BW_SET];
  wire [BW_SET-1:0] victim_way = addr_o[BW_CACHE_CAPACITY-1 -: BW_SET];

`ifdef SRRIP_BIMODAL_INSERT_EN
  logic [4:0] bim_cnt_q;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) bim_cnt_q <= '0;
    else           bim_cnt_q <= bim_cnt_q + 5'd1;
  end

  assign ins_val = (bim_cnt_q == 5'd0) ? RRPV_LONG : RRPV_MAX;
`else
  assign ins_val = RRPV_LONG;
`endif

  // Scanning downwards leaves the lowest-index distant way as the winner.
  always_comb begin
    found     = 1'b0;
    found_way = '0;
    for (int w = CACHE_SET_SIZE - 1; w >= 0; w--) begin
      if (rrpv_q[grp_q][w] == RRPV_MAX) begin
        found     = 1'b1;
        found_way = BW_SET'(w);
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (miss_i) state_d = S_SEARCH;
      S_SEARCH: state_d = found ? S_DONE : S_AGE;
      S_AGE:    state_d = S_SEARCH;
      S_DONE:   state_d = S_WAIT;
      S_WAIT:   if (!miss_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      addr_o  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && miss_i) grp_q <= hit_grp;
      if (state_q == S_SEARCH && found) addr_o <= {found_way, grp_q};
    end
  end

  // NOTE: the RRPV array is flip-flops, not RAM, so the whole array is reset to RRPV_MAX.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int g = 0; g < N_GROUPS; g++)
        for (int w = 0; w < CACHE_SET_SIZE; w++)
          rrpv_q[g][w] <= RRPV_MAX;
    end else begin
      for (int g = 0; g < N_GROUPS; g++) begin
        for (int w = 0; w < CACHE_SET_SIZE; w++) begin
          // Insertion beats a hit to the victim; a hit beats aging.
          if (state_q == S_DONE && BW_GRP'(g) == grp_q && BW_SET'(w) == victim_way)
            rrpv_q[g][w] <= ins_val;
          else if (hit_i && BW_GRP'(g) == hit_grp && BW_SET'(w) == hit_way)
            rrpv_q[g][w] <= '0;
          else if (state_q == S_AGE && BW_GRP'(g) == grp_q && rrpv_q[g][w] != RRPV_MAX)
            rrpv_q[g][w] <= rrpv_q[g][w] + BW_RRPV'(1);
        end
      end
    end
  end

  assign done_o = (state_q == S_DONE);
  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_set_cache_srrip_policy_controller.sv
// Directed bench for the SRRIP controller (128 blocks, 4 ways, 2-bit RRPV).
// Define SRRIP_BIMODAL_INSERT_EN for the bimodal insertion scenario.
module tb_set_cache_srrip_policy_controller;

  localparam int CAP  = 128;
  localparam int WAYS = 4;
  localparam int BWR  = 2;
  localparam int BW   = 7;
  localparam int NGRP = 32;

  logic          clock_i = 1'b0;
  logic          resetn_i;
  logic          hit_i;
  logic          miss_i;
  logic [BW-1:0] addr_i;
  logic          done_o;
  logic          busy_o;
  logic [BW-1:0] addr_o;

  set_cache_srrip_policy_controller #(
    .CACHE_BLOCK_CAPACITY(CAP),
    .CACHE_SET_SIZE(WAYS),
    .BW_RRPV(BWR)
  ) dut (
    .clock_i (clock_i),
    .resetn_i(resetn_i),
    .hit_i   (hit_i),
    .miss_i  (miss_i),
    .addr_i  (addr_i),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .addr_o  (addr_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          hit;
    logic          miss;
    logic [BW-1:0] addr;
    logic          exp_done;
    logic          exp_busy;
    logic [BW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [BW-1:0] ba(input int way, input int grp);
    logic [31:0] v;
    v = (way << 5) | grp;
    return v[BW-1:0];
  endfunction

  function automatic int rrpv(input int g, input int w);
    return int'(dut.rrpv_q[g][w]);
  endfunction

  function automatic int count_rrpv_not(input int val);
    int n = 0;
    for (int g = 0; g < NGRP; g++)
      for (int w = 0; w < WAYS; w++)
        if (rrpv(g, w) != val) n++;
    return n;
  endfunction

  task automatic do_reset();
    hit_i = 1'b0; miss_i = 1'b0; addr_i = '0;
    resetn_i = 1'b0;
    step();
    step();
    resetn_i = 1'b1;
  endtask

  task automatic do_hit(input int way, input int grp);
    hit_i  = 1'b1;
    addr_i = ba(way, grp);
    step();
    hit_i  = 1'b0;
  endtask

  // Returns the number of edges from asserting miss_i to seeing done_o; 0 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done_o) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int e;
    int pulses;
    int low_busy;
    int n2;

    vecs[0] = '{1'b0, 1'b1, ba(0, 5), 1'b0, 1'b1, 7'd0};
    vecs[1] = '{1'b0, 1'b1, ba(0, 5), 1'b1, 1'b1, 7'd5};
    vecs[2] = '{1'b0, 1'b1, ba(0, 5), 1'b0, 1'b1, 7'd5};
    vecs[3] = '{1'b0, 1'b0, ba(0, 5), 1'b0, 1'b0, 7'd5};
    vecs[4] = '{1'b0, 1'b0, ba(0, 5), 1'b0, 1'b0, 7'd5};
    vecs[5] = '{1'b0, 1'b1, ba(0, 5), 1'b0, 1'b1, 7'd5};
    vecs[6] = '{1'b0, 1'b1, ba(0, 5), 1'b1, 1'b1, 7'd37};
    vecs[7] = '{1'b0, 1'b0, ba(0, 5), 1'b0, 1'b1, 7'd37};
    vecs[8] = '{1'b0, 1'b0, ba(0, 5), 1'b0, 1'b0, 7'd37};
    vecs[9] = '{1'b1, 1'b0, ba(2, 7), 1'b0, 1'b0, 7'd37};

    // Reset state
    do_reset();
    check("reset_done", done_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_addr", addr_o, 0);
    check("reset_rrpv_not_max", count_rrpv_not(3), 0);

    // Cycle table: miss to group 5 twice, then a hit to group 7 way 2
    for (int i = 0; i < 10; i++) begin
      hit_i  = vecs[i].hit;
      miss_i = vecs[i].miss;
      addr_i = vecs[i].addr;
      step();
      check($sformatf("vec%0d_done", i), done_o, vecs[i].exp_done);
      check($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
      check($sformatf("vec%0d_addr", i), addr_o, vecs[i].exp_addr);
    end
    hit_i = 1'b0;
    check("g5_w0_inserted", rrpv(5, 0), 2);
    check("g5_w1_inserted", rrpv(5, 1), 2);
    check("g5_w2_untouched", rrpv(5, 2), 3);
    check("g7_w2_hit", rrpv(7, 2), 0);

    // Three aging passes on group 3, then miss_i held for 10 cycles
    for (int w = 0; w < WAYS; w++) do_hit(w, 3);
    miss_i = 1'b1; addr_i = ba(0, 3);
    wait_done(e);
    check("age3_latency", e, 8);
    check("age3_victim", addr_o, 3);
    pulses = 0; low_busy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o) pulses++;
      if (!busy_o) low_busy++;
    end
    check("hold_extra_done", pulses, 0);
    check("hold_busy_low", low_busy, 0);
    for (int w = 0; w < WAYS; w++) check($sformatf("age3_g3_w%0d", w), rrpv(3, w), (w == 0) ? 2 : 3);
    miss_i = 1'b0;
    step();
    check("hold_busy_release", busy_o, 0);

    // Hits to group 3 way 1 during each AGE pass
    for (int w = 0; w < WAYS; w++) do_hit(w, 3);
    miss_i = 1'b1; addr_i = ba(0, 3);
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("agehit_done_e%0d", i), done_o, (i == 8) ? 1 : 0);
      hit_i  = (i == 2 || i == 4 || i == 6);
      addr_i = hit_i ? ba(1, 3) : ba(0, 3);
    end
    hit_i = 1'b0;
    check("agehit_victim", addr_o, 3);
    miss_i = 1'b0;
    step();
    step();
    check("agehit_g3_w0", rrpv(3, 0), 2);
    check("agehit_g3_w1", rrpv(3, 1), 0);
    check("agehit_g3_w2", rrpv(3, 2), 3);
    check("agehit_g3_w3", rrpv(3, 3), 3);
    n2 = 0;
    for (int w = 0; w < WAYS; w++) if (rrpv(2, w) != 3) n2++;
    check("g2_untouched", n2, 0);

    // Reset asserted during AGE
    for (int w = 0; w < WAYS; w++) do_hit(w, 4);
    miss_i = 1'b1; addr_i = ba(0, 4);
    step();
    step();
    #2 resetn_i = 1'b0;
    #1;
    check("abort_done", done_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_addr", addr_o, 0);
    check("abort_rrpv_not_max", count_rrpv_not(3), 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done_o) pulses++;
    end
    check("abort_no_done", pulses, 0);
    resetn_i = 1'b1;
    wait_done(e);
    check("after_abort_latency", e, 2);
    check("after_abort_victim", addr_o, 4);
    miss_i = 1'b0;
    step();
    step();

`ifdef SRRIP_BIMODAL_INSERT_EN
    // 32 misses to fresh groups, five cycles apart so the counter phase walks all values
    do_reset();
    for (int g = 0; g < NGRP; g++) begin
      miss_i = 1'b1; addr_i = ba(0, g);
      wait_done(e);
      check($sformatf("bim_latency_g%0d", g), e, 2);
      miss_i = 1'b0;
      step();
      step();
      step();
    end
    n2 = 0;
    for (int g = 0; g < NGRP; g++) if (rrpv(g, 0) == 2) n2++;
    check("bim_long_inserts", n2, 1);
    n2 = 0;
    for (int g = 0; g < NGRP; g++) if (rrpv(g, 0) == 3) n2++;
    check("bim_distant_inserts", n2, 31);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
